calc_button_decoder: RTL and testbench
======================================

Name: calc_button_decoder

Overview:
- Input stage of the calculator. Takes the raw, asynchronous, bouncing keypad vector (calc_pkg::buttons_t) and produces debounced, one-hot-checked button events as calc_pkg::active_button_t.
- Feeds the calculator core. The core consumes exactly one button_valid_o pulse per physical press.
- Rollover is not supported: every key must be released before the next event is produced.

Parameters:
- DebounceCycles, default 20000: number of consecutive cycles the decoded input must be stable to accept a press or a release. Legal range is 1 or more.
- SyncStages, default 2: depth of the flop synchronizer on each buttons_i bit. Legal range is 2 or more.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- buttons_i  input  23 (calc_pkg::buttons_t)  raw keypad levels, asynchronous, 1 = pressed.
- button_o  output  5 (calc_pkg::active_button_t)  last accepted button. Holds its value between events.
- button_valid_o  output  1  single-cycle pulse. button_o is valid on this cycle.
- held_o  output  1  high while a press is accepted and not yet debounced as released.

Behaviour:
- Reset is asynchronous on rst_ni low, with synchronous deassertion assumed from the system reset generator. On reset:
  - all synchronizer flops clear to 0;
  - the FSM goes to S_IDLE;
  - the counter clears to 0;
  - the candidate register is set to B_NONE;
  - button_o = B_NONE, button_valid_o = 0, held_o = 0.
- Synchronizer: SyncStages flops per bit, no combining between bits.
- Encoder (combinational, on the synchronizer output):
  - no bits set gives B_NONE;
  - exactly one bit set gives the matching B_* enum value (for example, num_7 gives B_NUM_7, clear gives B_CLEAR);
  - two or more bits set gives B_UNKNOWN.
- Counter width is $clog2(DebounceCycles+1). The counter saturates and never wraps.
- FSM states: S_IDLE, S_DEB_PRESS, S_HELD, S_DEB_RELEASE.
- S_IDLE:
  - encoded != B_NONE: candidate <= encoded, counter <= 0, go to S_DEB_PRESS.
- S_DEB_PRESS:
  - encoded == B_NONE: go to S_IDLE.
  - encoded != candidate (and not B_NONE): candidate <= encoded, counter <= 0, stay.
  - encoded == candidate and counter == DebounceCycles-1: go to S_HELD. In the same edge, button_o <= candidate and button_valid_o <= 1. Exception: if candidate == B_UNKNOWN, do not pulse and leave button_o unchanged.
  - otherwise: counter++.
- S_HELD:
  - held_o = 1.
  - encoded == B_NONE: counter <= 0, go to S_DEB_RELEASE.
  - Any other change, including a move to B_UNKNOWN or to a different key, is ignored and no event is produced.
- S_DEB_RELEASE:
  - held_o = 1.
  - encoded != B_NONE: go to S_HELD.
  - encoded == B_NONE and counter == DebounceCycles-1: go to S_IDLE.
  - otherwise: counter++.
- held_o is registered from the next-state value. It is 1 in S_HELD and S_DEB_RELEASE.
- button_valid_o is high for exactly one cycle per accepted press and is never high on two consecutive cycles.
- Latency from a clean buttons_i edge to the button_valid_o pulse is SyncStages + DebounceCycles + 1 cycles.
- The minimum time between two events is (press latency) + (release debounce) + 1 cycle in S_IDLE.
- Reset mid-operation (any state) aborts the operation immediately. There is no pending pulse after reset deassertion.
- A single bit changing identity within S_DEB_PRESS restarts the count and never produces an event for the earlier key.

Test Plan (DebounceCycles = 4, SyncStages = 2, reset released at cycle 0):
- Clean press: num_7 rises at cycle 10 and is held for 20 cycles. Required: button_valid_o high only at cycle 17 with button_o = B_NUM_7, held_o high from cycle 17, held_o low 7 cycles after release, button_o stays B_NUM_7.
- Bounce rejection: num_3 pulses high for 3 cycles, then low for 2, then stays high. Required: no pulse during the glitches, a single pulse 7 cycles after the final rise, button_o = B_NUM_3.
- Chord: op_add and op_mul rise in the same cycle and are held for 10 cycles. Required: no button_valid_o, held_o goes high, button_o unchanged (B_NONE), held_o returns to 0 after release debounce.
- Hold, release glitch and rollover: dot is held 50 cycles with a 1-cycle 0-glitch at cycle 30, and num_0 is pressed at cycle 40 while dot is still held. Required: exactly one pulse (B_DOT) and no event for num_0 until everything is released and num_0 is re-pressed.
- Reset mid-debounce: press mem_recall at cycle 10 and assert rst_ni low at cycle 14 for 1 cycle. Required: all outputs 0 or B_NONE immediately, no pulse afterwards even though the key stays held, until the key is re-debounced from S_IDLE (pulse 7 cycles after rst_ni rises).
- Back-to-back keys: press num_1 and release it cleanly, wait until held_o is 0, then press num_2. Required: two pulses, B_NUM_1 then B_NUM_2, each one cycle long.

Source files
------------

// File: rtl/calc_button_decoder.sv
// calc_button_decoder: synchronizes, one-hot encodes and debounces the raw keypad
// into single-cycle button events for the calculator core.
`default_nettype none

package calc_pkg;
  localparam int NumButtons = 23;

  // Declared MSB first so that bit i of the vector maps to enum value i+1.
  typedef struct packed {
    logic mem_clear;
    logic mem_recall;
    logic mem_sub;
    logic mem_add;
    logic sign;
    logic all_clear;
    logic clear;
    logic equals;
    logic op_div;
    logic op_mul;
    logic op_sub;
    logic op_add;
    logic dot;
    logic num_9;
    logic num_8;
    logic num_7;
    logic num_6;
    logic num_5;
    logic num_4;
    logic num_3;
    logic num_2;
    logic num_1;
    logic num_0;
  } buttons_t;

  typedef enum logic [4:0] {
    B_NONE       = 5'd0,
    B_NUM_0      = 5'd1,
    B_NUM_1      = 5'd2,
    B_NUM_2      = 5'd3,
    B_NUM_3      = 5'd4,
    B_NUM_4      = 5'd5,
    B_NUM_5      = 5'd6,
    B_NUM_6      = 5'd7,
    B_NUM_7      = 5'd8,
    B_NUM_8      = 5'd9,
    B_NUM_9      = 5'd10,
    B_DOT        = 5'd11,
    B_OP_ADD     = 5'd12,
    B_OP_SUB     = 5'd13,
    B_OP_MUL     = 5'd14,
    B_OP_DIV     = 5'd15,
    B_EQUALS     = 5'd16,
    B_CLEAR      = 5'd17,
    B_ALL_CLEAR  = 5'd18,
    B_SIGN       = 5'd19,
    B_MEM_ADD    = 5'd20,
    B_MEM_SUB    = 5'd21,
    B_MEM_RECALL = 5'd22,
    B_MEM_CLEAR  = 5'd23,
    B_UNKNOWN    = 5'd31
  } active_button_t;
endpackage

module calc_button_decoder
  import calc_pkg::*;
#(
  parameter int DebounceCycles = 20000,
  parameter int SyncStages     = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  buttons_t       buttons_i,
  output active_button_t button_o,
  output logic           button_valid_o,
  output logic           held_o
);

  localparam int CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DebounceCycles);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_DEB_PRESS   = 2'd1,
    S_HELD        = 2'd2,
    S_DEB_RELEASE = 2'd3
  } state_t;

  logic [SyncStages-1:0][NumButtons-1:0] sync_q;
  logic [NumButtons-1:0] sync_out;
  logic [4:0]            hits;
  active_button_t        encoded;

  state_t               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d, cnt_inc;
  active_button_t       cand_q, cand_d, button_d;
  logic                 valid_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], buttons_i};
    end
  end

  assign sync_out = sync_q[SyncStages-1];

  always_comb begin
    encoded = B_NONE;
    hits    = 5'd0;
    for (int i = 0; i < NumButtons; i++) begin
      if (sync_out[i]) begin
        hits    = hits + 5'd1;
        encoded = active_button_t'(5'(i + 1));
      end
    end
    if (hits > 5'd1) encoded = B_UNKNOWN;
  end

  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    button_d = button_o;
    valid_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (encoded != B_NONE) begin
          cand_d  = encoded;
          cnt_d   = '0;
          state_d = S_DEB_PRESS;
        end
      end
      S_DEB_PRESS: begin
        if (encoded == B_NONE) begin
          state_d = S_IDLE;
        end else if (encoded != cand_q) begin
          cand_d = encoded;
          cnt_d  = '0;
        end else if (cnt_q == CntLast) begin
          state_d = S_HELD;
          // A chord still occupies the keypad but never reaches the core.
          if (cand_q != B_UNKNOWN) begin
            button_d = cand_q;
            valid_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_HELD: begin
        if (encoded == B_NONE) begin
          cnt_d   = '0;
          state_d = S_DEB_RELEASE;
        end
      end
      S_DEB_RELEASE: begin
        if (encoded != B_NONE) begin
          state_d = S_HELD;
        end else if (cnt_q == CntLast) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      cand_q         <= B_NONE;
      button_o       <= B_NONE;
      button_valid_o <= 1'b0;
      held_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cand_q         <= cand_d;
      button_o       <= button_d;
      button_valid_o <= valid_d;
      held_o         <= (state_d == S_HELD) || (state_d == S_DEB_RELEASE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_calc_button_decoder.sv
// tb_calc_button_decoder: directed scenarios with an event scoreboard checked
// against calc_button_decoder at DebounceCycles=4, SyncStages=2.
`default_nettype none

module tb_calc_button_decoder;
  import calc_pkg::*;

  localparam int DEB  = 4;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + DEB + 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  buttons_t       btn;
  active_button_t button;
  logic           valid;
  logic           held;

  calc_button_decoder #(.DebounceCycles(DEB), .SyncStages(SYNC)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .buttons_i      (btn),
    .button_o       (button),
    .button_valid_o (valid),
    .held_o         (held)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    active_button_t b;
    int             c;
  } ev_t;
  ev_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_event(input active_button_t b);
    ev_t e;
    e.b = b;
    e.c = cyc + LAT;
    exp_q.push_back(e);
  endtask

  // Scoreboard side: every pulse must match the oldest pending expectation.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    ev_t e;
    if (valid === 1'b1) begin
      check("pulse_single_cycle", 32'(prev_valid), 32'd0);
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_event: observed=%0d expected=none (cycle %0d)", button, cyc);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("event_button", 32'(button), 32'(e.b));
        check("event_cycle", 32'(cyc), 32'(e.c));
      end
    end
    prev_valid = valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    btn = '0;
    cycles(3);
    check("reset_button", 32'(button), 32'(B_NONE));
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_held", 32'(held), 32'd0);
    rst_n = 1'b1;
    cycles(2);

    // Chord: held but no event, button_o untouched.
    btn.op_add = 1'b1;
    btn.op_mul = 1'b1;
    cycles(LAT - 1);
    check("chord_held_early", 32'(held), 32'd0);
    cycles(1);
    check("chord_held", 32'(held), 32'd1);
    check("chord_button", 32'(button), 32'(B_NONE));
    cycles(10 - LAT);
    btn = '0;
    cycles(LAT - 1);
    check("chord_release_held", 32'(held), 32'd1);
    cycles(1);
    check("chord_release_done", 32'(held), 32'd0);
    cycles(3);

    // Clean press.
    btn.num_7 = 1'b1;
    expect_event(B_NUM_7);
    cycles(LAT - 1);
    check("clean_held_early", 32'(held), 32'd0);
    cycles(1);
    check("clean_held", 32'(held), 32'd1);
    check("clean_button", 32'(button), 32'(B_NUM_7));
    cycles(20 - LAT);
    btn = '0;
    cycles(LAT - 1);
    check("clean_release_held", 32'(held), 32'd1);
    cycles(1);
    check("clean_release_done", 32'(held), 32'd0);
    check("clean_button_kept", 32'(button), 32'(B_NUM_7));
    cycles(3);

    // Bounce: 3 high, 2 low, then stable high.
    btn.num_3 = 1'b1;
    cycles(3);
    btn.num_3 = 1'b0;
    cycles(2);
    btn.num_3 = 1'b1;
    expect_event(B_NUM_3);
    cycles(LAT - 1);
    check("bounce_held_early", 32'(held), 32'd0);
    cycles(1);
    check("bounce_held", 32'(held), 32'd1);
    check("bounce_button", 32'(button), 32'(B_NUM_3));
    cycles(5);
    btn = '0;
    cycles(LAT);
    check("bounce_release_done", 32'(held), 32'd0);
    cycles(3);

    // Long hold with a release glitch and a rollover attempt.
    btn.dot = 1'b1;
    expect_event(B_DOT);
    cycles(30);
    btn.dot = 1'b0;
    cycles(1);
    btn.dot = 1'b1;
    cycles(3);
    check("glitch_held", 32'(held), 32'd1);
    cycles(6);
    btn.num_0 = 1'b1;
    cycles(10);
    btn.dot = 1'b0;
    cycles(LAT + 3);
    check("rollover_held", 32'(held), 32'd1);
    check("rollover_button", 32'(button), 32'(B_DOT));
    btn.num_0 = 1'b0;
    cycles(LAT);
    check("rollover_release_done", 32'(held), 32'd0);
    cycles(2);
    btn.num_0 = 1'b1;
    expect_event(B_NUM_0);
    cycles(LAT);
    check("repress_button", 32'(button), 32'(B_NUM_0));
    cycles(3);
    btn = '0;
    cycles(LAT + 2);

    // Reset mid-debounce.
    btn.mem_recall = 1'b1;
    cycles(4);
    rst_n = 1'b0;
    #1;
    check("midreset_button", 32'(button), 32'(B_NONE));
    check("midreset_valid", 32'(valid), 32'd0);
    check("midreset_held", 32'(held), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_event(B_MEM_RECALL);
    cycles(LAT - 1);
    check("postreset_held_early", 32'(held), 32'd0);
    cycles(1);
    check("postreset_held", 32'(held), 32'd1);
    check("postreset_button", 32'(button), 32'(B_MEM_RECALL));
    btn = '0;
    cycles(LAT + 2);

    // Back-to-back keys.
    btn.num_1 = 1'b1;
    expect_event(B_NUM_1);
    cycles(10);
    btn = '0;
    n = 0;
    while (held && n < 20) begin
      cycles(1);
      n++;
    end
    check("b2b_release_bound", 32'(held), 32'd0);
    btn.num_2 = 1'b1;
    expect_event(B_NUM_2);
    cycles(LAT);
    check("b2b_second_button", 32'(button), 32'(B_NUM_2));
    cycles(5);
    btn = '0;
    cycles(LAT + 3);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
